// File: rtl/hazard_control.sv
// rtl/hazard_control.sv - load-use stall and redirect flush sequencer for the five-stage pipeline
// Optional performance counters are built only when HAZARD_PERF_EN is defined.
module hazard_control #(
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       FD_RS,
  input  logic [4:0]       FD_RT,
  input  logic             FD_useRT,
  input  logic [4:0]       DX_RD,
  input  logic             DX_lwFlag,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output logic             PC_write,
  output logic             FD_write,
  output logic             FD_flush,
  output logic             DX_bubble,
  output logic             PC_sel,
  output logic [31:0]      PC_target,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [2:0] CNT_INIT = 3'(FLUSH_DEPTH - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] pc_target_q, pc_target_d;
  logic        lu;

  // Register 0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign lu = DX_lwFlag & (DX_RD != 5'd0) &
              ((DX_RD == FD_RS) | (FD_useRT & (DX_RD == FD_RT)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      cnt_q       <= 3'd0;
      pc_target_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pc_target_q <= pc_target_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_target_d = pc_target_q;
    PC_write    = 1'b1;
    FD_write    = 1'b1;
    FD_flush    = 1'b0;
    DX_bubble   = 1'b0;
    PC_sel      = 1'b0;
    busy        = 1'b0;

    case (state_q)
      RUN: begin
        PC_write  = ~lu;
        FD_write  = ~lu;
        DX_bubble = lu;
      end
      FLUSH: begin
        // DX holds wrong-path work here, so the load-use check is not consulted.
        FD_flush  = 1'b1;
        DX_bubble = 1'b1;
        busy      = 1'b1;
        PC_sel    = (cnt_q == CNT_INIT);
        if (cnt_q == 3'd0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = RUN;
    endcase

    // A redirect always restarts the flush, overriding a stall or an ongoing sequence.
    if (redirect) begin
      state_d     = FLUSH;
      cnt_d       = CNT_INIT;
      pc_target_d = redirect_pc;
    end
  end

  assign PC_target = pc_target_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((state_q == RUN) && lu && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (redirect && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: doc/hazard_control.md
# hazard_control

Pipeline sequencing controller for the five-stage MIPS core. It gates the PC and the FD/DX pipeline registers around the execution stage. It detects load-use hazards against the instruction in DX and inserts bubbles. It also runs a flush sequence whenever the execution stage resolves a taken beq/bne or a j. It sits beside the execution stage and drives the PC mux and the write/flush enables of the fetch, decode and execute pipeline registers.

## Interface
- FLUSH_DEPTH, 2: number of cycles squashed after a redirect; legal range 1..7.
- CNT_W, 16: width of the performance counters.

- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- FD_RS  input  5  rs field of the instruction in decode.
- FD_RT  input  5  rt field of the instruction in decode.
- FD_useRT  input  1  decode instruction reads rt (R-type, beq, bne, sw).
- DX_RD  input  5  destination register of the instruction in DX.
- DX_lwFlag  input  1  DX instruction is lw.
- redirect  input  1  execution stage resolved a taken branch or jump this cycle.
- redirect_pc  input  32  target address accompanying redirect.
- PC_write  output  1  PC register enable.
- FD_write  output  1  FD pipeline register enable.
- FD_flush  output  1  clear the FD register to a nop.
- DX_bubble  output  1  load a nop (RD=0, all flags 0) into DX.
- PC_sel  output  1  1 selects PC_target as the next PC, 0 selects PC+4.
- PC_target  output  32  registered redirect target.
- busy  output  1  controller is in the FLUSH state.
- stall_cnt  output  CNT_W  load-use stall cycles; see Configuration.
- flush_cnt  output  CNT_W  redirect events; see Configuration.

## Operation
- States: RUN and FLUSH. A down-counter cnt is 3 bits wide.
- Load-use hazard, evaluated combinationally:
  - lu = DX_lwFlag & (DX_RD != 0) & ((DX_RD == FD_RS) | (FD_useRT & (DX_RD == FD_RT))).
- RUN with lu=1: PC_write=0, FD_write=0, DX_bubble=1, FD_flush=0, PC_sel=0.
- RUN with lu=0: PC_write=1, FD_write=1, DX_bubble=0, FD_flush=0, PC_sel=0.
- Transition RUN→FLUSH: on any edge where redirect=1.
  - PC_target ← redirect_pc; cnt ← FLUSH_DEPTH-1.
- FLUSH outputs:
  - PC_write=1, FD_write=1, FD_flush=1, DX_bubble=1, busy=1.
  - PC_sel=1 only while cnt==FLUSH_DEPTH-1, i.e. the first FLUSH cycle; PC_sel=0 otherwise.
  - lu is ignored, because the DX contents are wrong-path.
- Within FLUSH: cnt decrements each cycle. On the edge where cnt==0 and redirect=0, go to RUN.
- Redirect arriving during FLUSH: restart the sequence. PC_target is reloaded, cnt ← FLUSH_DEPTH-1, and PC_sel is asserted again on the following cycle.
- Redirect arriving in RUN in the same cycle as lu=1: the stall outputs apply for that cycle only. The redirect wins at the edge, and the next state is FLUSH.
- Register 0 never creates a hazard.

## Timing
- Load-use response is combinational, with zero-cycle latency. One bubble per lw dependency: the following cycle the lw has left DX, so lu clears naturally.
- Redirect response has 1-cycle latency. redirect is sampled at edge N. PC_sel, PC_target and the flushes are valid in cycle N+1. FLUSH lasts exactly FLUSH_DEPTH cycles, after which the block returns to RUN.
- Reset (rst=0) is asynchronous and immediate. Reset values:
  - state RUN, cnt 0, PC_target 0, stall_cnt 0, flush_cnt 0.
  - Resulting outputs: PC_write=1, FD_write=1, FD_flush=0, DX_bubble=0, PC_sel=0, busy=0.
- Reset during FLUSH aborts the sequence. The first cycle after release is RUN.

## Configuration
- HAZARD_PERF_EN defined:
  - stall_cnt increments on each clock where state is RUN and lu=1.
  - flush_cnt increments on each edge where redirect=1.
  - Both counters saturate at all-ones and are cleared only by reset.
- HAZARD_PERF_EN undefined: no counter flops are built, and stall_cnt and flush_cnt are tied to 0.

## Test plan
- Reset: drive rst=0 with redirect=1 and redirect_pc=0x40 → PC_write=1, busy=0, PC_target=0; after release, the first cycle is RUN.
- Load-use hazard: DX_lwFlag=1, DX_RD=8, FD_RS=8 → same cycle PC_write=0, FD_write=0, DX_bubble=1. Repeat with DX_RD=0 → no stall.
- rt dependency: DX_RD=9, FD_RT=9, FD_useRT=0 → no stall; with FD_useRT=1 → stall.
- Redirect with FLUSH_DEPTH=2: redirect=1 with redirect_pc=0x00400020 for one cycle →
  - next cycle: PC_sel=1, PC_target=0x00400020, FD_flush=1, DX_bubble=1;
  - following cycle: PC_sel=0, flushes still 1;
  - third cycle: RUN.
- Back-to-back redirects: redirect at cycles N (0x100) and N+1 (0x200) → PC_sel=1 in N+1 and N+2, PC_target=0x200 at N+2, FLUSH ends at N+3.
- Counters, with HAZARD_PERF_EN defined: three load-use stalls and two redirects → stall_cnt=3, flush_cnt=2. With CNT_W=2 and five redirects → flush_cnt holds at 3.
